ctrl_initiator: RTL and testbench
=================================

CTRL_INITIATOR -- requirements
Module: ctrl_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the response-wait limit in clk cycles when the timeout feature is compiled in; legal range 1..2^16-1.
REQ-002 Ports SHALL be, one per line, as follows.
- clk  input  1  single clock; all logic on posedge clk
- res_n  input  1  reset, synchronous, active-low
- m_axi  if_axi_light.master  --  AXI-lite master port, widths `AXI_ADDR_WIDTH / `AXI_DATA_WIDTH / `AXI_WSTRB_WIDTH
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted this cycle when high with cmd_valid
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  `AXI_ADDR_WIDTH  target address (e.g. control PROG/BUSY/SPOON_FEED index bits)
- cmd_wdata  input  `AXI_DATA_WIDTH  write data
- cmd_wstrb  input  `AXI_WSTRB_WIDTH  write strobes
- cmd_prot  input  3  AxPROT value
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed
- rsp_rdata  output  `AXI_DATA_WIDTH  read data (0 for writes)
- rsp_resp  output  2  BRESP/RRESP as received
- rsp_timeout  output  1  response produced by timeout (0 without feature)
- busy  output  1  high in any state other than IDLE

Function
REQ-003 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-004 cmd_ready SHALL be high only in IDLE; on cmd_valid&&cmd_ready all cmd_* fields SHALL be latched and the FSM SHALL enter WR_REQ (write) or RD_REQ (read).
REQ-005 AWVALID and WVALID SHALL both rise the cycle after acceptance, each SHALL stay high until its own handshake, and once high SHALL not drop before that handshake; AW and W may complete in either order or the same cycle.
REQ-006 WR_REQ SHALL move to WR_RESP the cycle after both AW and W handshakes have completed; BREADY SHALL be high in WR_RESP only.
REQ-007 ARVALID SHALL rise the cycle after acceptance and hold until ARREADY; RD_REQ SHALL then move to RD_RESP, where RREADY SHALL be high.
REQ-008 On BVALID&&BREADY or RVALID&&RREADY the FSM SHALL capture resp (and rdata for reads, 0 for writes) and enter RSP; rsp_valid SHALL be high exactly in RSP.
REQ-009 rsp_* SHALL hold stable while rsp_valid&&!rsp_ready; on rsp_ready the FSM SHALL return to IDLE, so the next command is acceptable no earlier than the following cycle.
REQ-010 Minimum latency SHALL be: accept at cycle N, AxVALID at N+1, rsp_valid at N+3 when slave readies and responses are all immediate.
REQ-011 Non-OKAY responses SHALL be forwarded unchanged in rsp_resp; no retry.
REQ-012 Only one transaction SHALL be outstanding; all AXI IDs/unused signals SHALL be driven by the interface default task each cycle.

Reset
REQ-013 With res_n low at a posedge, the FSM SHALL go to IDLE and all valids/readies, rsp_*, busy, and the timeout counter SHALL be 0 after that edge, including mid-transaction; an in-flight transaction SHALL produce no response.
REQ-014 cmd_ready SHALL be 0 during reset and 1 in the first cycle after res_n returns high.

Configuration
REQ-015 With CTRL_INITIATOR_TIMEOUT_EN defined, a counter SHALL clear on entering WR_RESP/RD_RESP, count each cycle there, and when it reaches TIMEOUT_CYCLES SHALL drop BREADY/RREADY and enter RSP with rsp_resp=2'b10, rsp_rdata=0, rsp_timeout=1.
REQ-016 AW/W/AR waits SHALL never time out (AXI forbids withdrawing VALID).
REQ-017 Without CTRL_INITIATOR_TIMEOUT_EN, no counter SHALL be synthesised, rsp_timeout SHALL be tied 0, and response waits SHALL be unbounded.

Structure
REQ-018 The FSM state enum and the response codes RESP_OKAY/RESP_SLVERR SHALL live in shared package ctrl_pkg.
REQ-019 The timeout counter SHALL be sub-module ctrl_timeout_cnt (inputs clk, res_n, clr, en; output expired), instantiated only under the macro.

Verification
REQ-020 Write addr=0x0000_0080 data=0x0000_1000, slave readies immediately -> AW/W at N+1, BREADY, rsp_valid at N+3, rsp_resp=0, rsp_rdata=0.
REQ-021 Read addr with bit 20 set, slave returns 0xDEAD_BEEF after 4 cycles -> rsp_rdata=0xDEAD_BEEF, rsp_resp=0, ARVALID held until ARREADY.
REQ-022 Write with WREADY 3 cycles before AWREADY -> WVALID drops after the W handshake, AWVALID stays high, a single B is accepted.
REQ-023 rsp_ready held low for 5 cycles with cmd_valid high -> rsp stable, cmd_ready 0 throughout, next command accepted the cycle after rsp_ready.
REQ-024 res_n low while in RD_RESP -> no rsp_valid, ARVALID/RREADY 0 after the edge, IDLE next.
REQ-025 Macro on, TIMEOUT_CYCLES=8, slave never asserts BVALID -> rsp_valid after 8 WR_RESP cycles, rsp_resp=2'b10, rsp_timeout=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the control-register AXI-lite initiator: FSM state encoding and
// AXI response codes. Also provides default AXI-lite widths when the build does not.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_WSTRB_WIDTH
`define AXI_WSTRB_WIDTH 4
`endif

package ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrReq  = 3'd1,
    StWrResp = 3'd2,
    StRdReq  = 3'd3,
    StRdResp = 3'd4,
    StRsp    = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/if_axi_light.sv
// AXI-lite bundle (no IDs, single outstanding) with master/slave views.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_WSTRB_WIDTH
`define AXI_WSTRB_WIDTH 4
`endif

interface if_axi_light;
  logic [`AXI_ADDR_WIDTH-1:0]  awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [`AXI_DATA_WIDTH-1:0]  wdata;
  logic [`AXI_WSTRB_WIDTH-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [`AXI_ADDR_WIDTH-1:0]  araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [`AXI_DATA_WIDTH-1:0]  rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ctrl_timeout_cnt.sv
// Response-wait watchdog: counts cycles spent waiting for B/R and flags the last
// allowed cycle. Only instantiated when CTRL_INITIATOR_TIMEOUT_EN is defined.
module ctrl_timeout_cnt #(
  parameter int unsigned Limit = 1024
) (
  input  logic clk,
  input  logic res_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt_q;

  // Cycle counter, cleared on entry to a response wait.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // High during the Limit-th waiting cycle, so the wait lasts exactly Limit cycles.
  assign expired = en && (cnt_q == 16'(Limit - 1));

endmodule

// File: rtl/ctrl_initiator.sv
// Single-outstanding AXI-lite initiator for control-register accesses.
// Accepts one command, runs the AW/W/B or AR/R exchange, then holds the response
// until consumed. Define CTRL_INITIATOR_TIMEOUT_EN to bound B/R waits by
// TIMEOUT_CYCLES (timed-out responses report SLVERR with rsp_timeout set).
module ctrl_initiator
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        res_n,
  if_axi_light.master                 m_axi,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [`AXI_ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [`AXI_DATA_WIDTH-1:0]  cmd_wdata,
  input  logic [`AXI_WSTRB_WIDTH-1:0] cmd_wstrb,
  input  logic [2:0]                  cmd_prot,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [`AXI_DATA_WIDTH-1:0]  rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_timeout,
  output logic                        busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("ctrl_initiator: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e                        state_q, state_d;
  logic                          aw_done_q, aw_done_d;
  logic                          w_done_q, w_done_d;
  logic [`AXI_ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [`AXI_DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [`AXI_WSTRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic [2:0]                    prot_q, prot_d;
  logic [`AXI_DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]                    resp_q, resp_d;
  logic                          aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                          resp_expired;

`ifdef CTRL_INITIATOR_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic cnt_clr, cnt_en;

  assign cnt_en  = (state_q == StWrResp) || (state_q == StRdResp);
  assign cnt_clr = ((state_d == StWrResp) || (state_d == StRdResp)) && !cnt_en;

  ctrl_timeout_cnt #(
    .Limit(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .res_n  (res_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(resp_expired)
  );

  assign rsp_timeout = timeout_q;
`else
  assign resp_expired = 1'b0;
  assign rsp_timeout  = 1'b0;
`endif

  // AXI drive: valids/readies decoded from state; payload from the latched command.
  assign m_axi.awvalid = (state_q == StWrReq) && !aw_done_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = prot_q;
  assign m_axi.wvalid  = (state_q == StWrReq) && !w_done_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.bready  = (state_q == StWrResp) && !resp_expired;
  assign m_axi.arvalid = (state_q == StRdReq);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = prot_q;
  assign m_axi.rready  = (state_q == StRdResp) && !resp_expired;

  assign aw_hs = m_axi.awvalid && m_axi.awready;
  assign w_hs  = m_axi.wvalid && m_axi.wready;
  assign ar_hs = m_axi.arvalid && m_axi.arready;
  assign b_hs  = m_axi.bvalid && m_axi.bready;
  assign r_hs  = m_axi.rvalid && m_axi.rready;

  // Command side is gated by res_n so nothing is offered while reset is asserted.
  assign cmd_ready = res_n && (state_q == StIdle);
  assign rsp_valid = (state_q == StRsp);
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign busy      = (state_q != StIdle);

  // Next-state and capture logic.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    prot_d    = prot_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
`ifdef CTRL_INITIATOR_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          prot_d    = cmd_prot;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? StWrReq : StRdReq;
        end
      end
      StWrReq: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // AW and W complete independently; leave once both have gone.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StWrResp;
      end
      StWrResp: begin
        if (resp_expired) begin
          resp_d    = RESP_SLVERR;
          rdata_d   = '0;
`ifdef CTRL_INITIATOR_TIMEOUT_EN
          timeout_d = 1'b1;
`endif
          state_d   = StRsp;
        end else if (b_hs) begin
          resp_d    = m_axi.bresp;
          rdata_d   = '0;
`ifdef CTRL_INITIATOR_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d   = StRsp;
        end
      end
      StRdReq: begin
        if (ar_hs) state_d = StRdResp;
      end
      StRdResp: begin
        if (resp_expired) begin
          resp_d    = RESP_SLVERR;
          rdata_d   = '0;
`ifdef CTRL_INITIATOR_TIMEOUT_EN
          timeout_d = 1'b1;
`endif
          state_d   = StRsp;
        end else if (r_hs) begin
          resp_d    = m_axi.rresp;
          rdata_d   = m_axi.rdata;
`ifdef CTRL_INITIATOR_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d   = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      prot_q    <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
`ifdef CTRL_INITIATOR_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      prot_q    <= prot_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
`ifdef CTRL_INITIATOR_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_ctrl_initiator.sv
// Bench for ctrl_initiator: randomized commands against a planned AXI-lite slave,
// expected responses and latencies from a transaction-level model, scoreboard monitor.
module tb_ctrl_initiator;
  import ctrl_pkg::*;

  localparam int unsigned TO = 8;
  localparam int A = `AXI_ADDR_WIDTH;
  localparam int D = `AXI_DATA_WIDTH;
  localparam int S = `AXI_WSTRB_WIDTH;

  logic         clk = 1'b0;
  logic         res_n = 1'b0;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [A-1:0] cmd_addr;
  logic [D-1:0] cmd_wdata;
  logic [S-1:0] cmd_wstrb;
  logic [2:0]   cmd_prot;
  logic         rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [D-1:0] rsp_rdata;
  logic [1:0]   rsp_resp;

  if_axi_light axi();

  ctrl_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .res_n(res_n), .m_axi(axi),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           write;
    logic [A-1:0] addr;
    logic [D-1:0] wdata;
    logic [S-1:0] wstrb;
    logic [2:0]   prot;
    int unsigned  aw_dly, w_dly, ar_dly, resp_dly;
    logic [1:0]   resp;
    logic [D-1:0] rdata;
    bit           no_resp;
  } plan_t;

  typedef struct {
    logic [D-1:0] rdata;
    logic [1:0]   resp;
    logic         timeout;
    int unsigned  lat;
  } exp_t;

  plan_t       plan_q[$];
  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic        rst_edge = 1'b1;
  bit          outstanding = 0;
  bit          rsp_pending = 0;
  bit          cur_ok = 0;
  int unsigned accept_cyc = 0;
  exp_t        cur;
  int          rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_edge <= !res_n;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Transaction-level model: response content and cycles from accept to rsp_valid.
  function automatic exp_t model(plan_t p);
    exp_t        e;
    int unsigned req;
    req = p.write ? ((p.aw_dly > p.w_dly) ? p.aw_dly : p.w_dly) : p.ar_dly;
    e.timeout = p.no_resp;
    if (p.no_resp) begin
      e.rdata = '0;
      e.resp  = RESP_SLVERR;
      e.lat   = 2 + req + TO;
    end else begin
      e.rdata = p.write ? '0 : p.rdata;
      e.resp  = p.resp;
      e.lat   = 3 + req + p.resp_dly;
    end
    return e;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    p.write    = 1'($urandom_range(0, 1));
    p.addr     = A'($urandom);
    p.wdata    = D'($urandom);
    p.wstrb    = S'($urandom);
    p.prot     = 3'($urandom_range(0, 7));
    p.aw_dly   = $urandom_range(0, 4);
    p.w_dly    = $urandom_range(0, 4);
    p.ar_dly   = $urandom_range(0, 4);
    p.resp_dly = $urandom_range(0, 4);
    p.resp     = 2'($urandom_range(0, 3));
    p.rdata    = D'($urandom);
    p.no_resp  = 0;
    return p;
  endfunction

  // ---------------- Scoreboard / protocol monitor ----------------
  always @(negedge clk) begin
    if (rst_edge) begin
      check("reset_ctrl_zero", 64'({rsp_valid, busy, axi.awvalid, axi.wvalid, axi.arvalid,
                                    axi.bready, axi.rready, rsp_timeout}), 64'd0);
      check("reset_rsp_data", 64'({rsp_rdata, rsp_resp}), 64'd0);
      outstanding = 0;
      rsp_pending = 0;
      sb_q.delete();
    end
    check("cmd_ready", 64'(cmd_ready), 64'(res_n && !outstanding));
    check("busy", 64'(busy), 64'(outstanding));
    if (rsp_valid) begin
      check("rsp_axi_quiet", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}),
            64'd0);
      if (!rsp_pending) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          cur_ok = 0;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          cur = sb_q.pop_front();
          cur_ok = 1;
          check("rsp_latency", 64'(cyc - accept_cyc), 64'(cur.lat));
        end
      end
      if (cur_ok) begin
        check("rsp_rdata", 64'(rsp_rdata), 64'(cur.rdata));
        check("rsp_resp", 64'(rsp_resp), 64'(cur.resp));
        check("rsp_timeout", 64'(rsp_timeout), 64'(cur.timeout));
      end
      rsp_pending = !rsp_ready;
      if (rsp_ready) outstanding = 0;
    end else if (rsp_pending) begin
      check("rsp_held", 64'(rsp_valid), 64'd1);
      rsp_pending = 0;
    end
    if (cmd_valid && cmd_ready) begin
      outstanding = 1;
      accept_cyc  = cyc;
    end
  end

  // ---------------- AXI-lite slave following the plan queue ----------------
  task automatic slave_idle();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;   axi.rresp = 2'b00;
  endtask

  task automatic resp_phase(input plan_t p);
    int unsigned n = 0;
    forever begin
      @(negedge clk);
      axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
      if (!res_n) begin slave_idle(); return; end
      if (n > 200) begin
        check("resp_wait_bound", 64'(n), 64'd200);
        slave_idle();
        return;
      end
      if (p.no_resp) begin
        if (!(p.write ? axi.bready : axi.rready)) begin
          check("timeout_ready_cycles", 64'(n), 64'(TO - 1));
          return;
        end
      end else if (p.write) begin
        axi.bvalid = (n >= p.resp_dly);
        axi.bresp  = p.resp;
        if (axi.bvalid && axi.bready) begin
          @(posedge clk); #1 axi.bvalid = 1'b0;
          return;
        end
      end else begin
        axi.rvalid = (n >= p.resp_dly);
        axi.rresp  = p.resp;
        axi.rdata  = p.rdata;
        if (axi.rvalid && axi.rready) begin
          @(posedge clk); #1 axi.rvalid = 1'b0;
          return;
        end
      end
      n++;
    end
  endtask

  task automatic slave_write(input plan_t p);
    int unsigned n = 0;
    bit aw_got = 0, w_got = 0, first = 1;
    while (!(aw_got && w_got)) begin
      if (!first) @(negedge clk);
      first = 0;
      if (!res_n) begin slave_idle(); return; end
      if (n > 100) begin
        check("aw_w_wait_bound", 64'(n), 64'd100);
        slave_idle();
        return;
      end
      check("awvalid_until_hs", 64'(axi.awvalid), 64'(!aw_got));
      check("wvalid_until_hs", 64'(axi.wvalid), 64'(!w_got));
      axi.awready = (n >= p.aw_dly) && !aw_got;
      axi.wready  = (n >= p.w_dly) && !w_got;
      if (axi.awvalid && axi.awready) begin
        check("awaddr", 64'(axi.awaddr), 64'(p.addr));
        check("awprot", 64'(axi.awprot), 64'(p.prot));
        aw_got = 1;
      end
      if (axi.wvalid && axi.wready) begin
        check("wdata", 64'(axi.wdata), 64'(p.wdata));
        check("wstrb", 64'(axi.wstrb), 64'(p.wstrb));
        w_got = 1;
      end
      n++;
    end
    resp_phase(p);
  endtask

  task automatic slave_read(input plan_t p);
    int unsigned n = 0;
    bit ar_got = 0, first = 1;
    while (!ar_got) begin
      if (!first) @(negedge clk);
      first = 0;
      if (!res_n) begin slave_idle(); return; end
      if (n > 100) begin
        check("ar_wait_bound", 64'(n), 64'd100);
        slave_idle();
        return;
      end
      check("arvalid_until_hs", 64'(axi.arvalid), 64'd1);
      axi.arready = (n >= p.ar_dly);
      if (axi.arvalid && axi.arready) begin
        check("araddr", 64'(axi.araddr), 64'(p.addr));
        check("arprot", 64'(axi.arprot), 64'(p.prot));
        ar_got = 1;
      end
      n++;
    end
    resp_phase(p);
  endtask

  initial begin
    plan_t p;
    slave_idle();
    forever begin
      @(negedge clk);
      if (res_n && (axi.awvalid || axi.wvalid || axi.arvalid)) begin
        if (plan_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unplanned_request: got AXI request expected none (cycle %0d)", cyc);
        end else begin
          p = plan_q.pop_front();
          check("req_kind", 64'({axi.awvalid, axi.wvalid, axi.arvalid}),
                p.write ? 64'd6 : 64'd1);
          if (p.write) slave_write(p);
          else slave_read(p);
        end
      end
    end
  end

  // ---------------- Response consumer ----------------
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       rsp_ready = 1'b0;
        2:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // ---------------- Stimulus ----------------
  task automatic start_cmd(input plan_t p);
    plan_q.push_back(p);
    sb_q.push_back(model(p));
    cmd_valid = 1'b1;
    cmd_write = p.write;
    cmd_addr  = p.addr;
    cmd_wdata = p.wdata;
    cmd_wstrb = p.wstrb;
    cmd_prot  = p.prot;
  endtask

  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) break;
      n++;
      if (n > 500) begin
        check("accept_bound", 64'(n), 64'd500);
        break;
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic issue(input plan_t p);
    start_cmd(p);
    wait_accept();
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || outstanding) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("drain_bound", 64'(n < 1000), 64'd1);
  endtask

  initial begin
    plan_t p;
    int    n;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0;   cmd_prot = 3'd0;
    repeat (3) @(posedge clk);
    #1 res_n = 1'b1;
    @(posedge clk);
    #1;

    // Write, slave ready immediately: minimum latency.
    p = rand_plan();
    p.write = 1; p.addr = A'(32'h0000_0080); p.wdata = D'(32'h0000_1000); p.wstrb = '1;
    p.prot = 3'd0; p.aw_dly = 0; p.w_dly = 0; p.resp_dly = 0; p.resp = RESP_OKAY;
    issue(p);

    // Read with address bit 20 set, slow AR and data 4 cycles late.
    p = rand_plan();
    p.write = 0; p.addr = A'(32'h0010_0000 | ($urandom & 32'hFFC)); p.ar_dly = 2;
    p.resp_dly = 4; p.resp = RESP_OKAY; p.rdata = D'(32'hDEAD_BEEF);
    issue(p);

    // W accepted three cycles before AW; error response forwarded unchanged.
    p = rand_plan();
    p.write = 1; p.w_dly = 0; p.aw_dly = 3; p.resp_dly = 1; p.resp = RESP_SLVERR;
    issue(p);

    // Response held for 5 cycles while the next command waits on cmd_valid.
    drain();
    rdy_mode = 1;
    p = rand_plan();
    p.write = 0; p.resp = 2'b11;
    issue(p);
    p = rand_plan();
    start_cmd(p);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("held_rsp_seen", 64'(rsp_valid), 64'd1);
    repeat (5) @(posedge clk);
    rdy_mode = 2;
    wait_accept();
    rdy_mode = 0;
    drain();

    // Reset while waiting for R: the read must vanish without a response.
    p = rand_plan();
    p.write = 0; p.ar_dly = 0; p.resp_dly = 50;
    issue(p);
    n = 0;
    while (!axi.rready && n < 100) begin @(negedge clk); n++; end
    check("rd_resp_reached", 64'(axi.rready), 64'd1);
    @(posedge clk);
    #1 res_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 res_n = 1'b1;
    @(posedge clk);
    #1;
    check("plan_flushed", 64'(plan_q.size()), 64'd0);

`ifdef CTRL_INITIATOR_TIMEOUT_EN
    // Slave never responds: write and read both time out.
    p = rand_plan();
    p.write = 1; p.no_resp = 1;
    issue(p);
    p = rand_plan();
    p.write = 0; p.no_resp = 1;
    issue(p);
`endif

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      p = rand_plan();
`ifdef CTRL_INITIATOR_TIMEOUT_EN
      p.no_resp = ($urandom_range(0, 7) == 0);
`endif
      issue(p);
    end
    drain();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected finish within 40000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
